// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/state types, the forward S-box table,
// the SubBytes controller state encoding and a lane-to-byte index helper.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  // Byte k of a state occupies bits [8k:8k+7]; byte 0 is the most significant.
  typedef logic [0:127] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  // AES forward S-box, indexed by byte value (hi nibble selects the row).
  localparam byte_t AES_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte position handled by a given lane on a given step.
  function automatic int lane_byte(input int step, input int lane, input int lanes);
    return step * lanes + lane;
  endfunction

endpackage

// File: rtl/sbox_byte.sv
// Single combinational AES forward S-box lookup (8 -> 8).
module sbox_byte
  import aes_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);

  assign dout = AES_SBOX[din];

endmodule

// File: rtl/subbytes_seq_ctrl.sv
// Sequential AES SubBytes controller: accepts one 128-bit state, substitutes
// LANES bytes per cycle through shared S-boxes and hands the result downstream.
// S-box lane inputs are forced to zero outside RUN so they do not toggle.
module subbytes_seq_ctrl
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] block_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] block_out,
  output logic         busy,
  output logic         sbox_en
);

  localparam int STEPS = 16 / LANES;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Only divisors of 16 give an integral number of steps per block.
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("subbytes_seq_ctrl: LANES must be 1, 2, 4, 8 or 16");
  end

  ctrl_state_e      state;
  logic [IDX_W-1:0] idx;
  state_t           state_reg;
  state_t           state_upd;
  byte_t            lane_in  [LANES];
  byte_t            lane_out [LANES];
  logic             last_step;

  assign last_step = (idx == IDX_W'(STEPS - 1));

  // Accept in IDLE, or in DONE when the current result leaves this same cycle.
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);

  // Isolated S-box lanes: each lane sees its byte of the current step only while enabled.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = sbox_en ? state_reg[8*lane_byte(int'(idx), l, LANES) +: 8] : 8'h00;

    sbox_byte u_sbox (
      .din  (lane_in[l]),
      .dout (lane_out[l])
    );
  end

  // Working state with this step's bytes replaced by their substitutes.
  always_comb begin
    // NOTE: default assignment first, so every path writes every bit and no latch is inferred.
    state_upd = state_reg;
    for (int l = 0; l < LANES; l++) begin
      state_upd[8*lane_byte(int'(idx), l, LANES) +: 8] = lane_out[l];
    end
  end

  // Controller FSM with step counter, working state and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: state_reg/block_out are plain flop banks, not a RAM, so resetting them is cheap and
      // guarantees a discarded block never leaks out after reset.
      state     <= IDLE;
      idx       <= '0;
      state_reg <= '0;
      block_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sbox_en   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= block_in;
            idx       <= '0;
            state     <= RUN;
            busy      <= 1'b1;
            sbox_en   <= 1'b1;
          end
        end
        RUN: begin
          state_reg <= state_upd;
          if (last_step) begin
            idx       <= '0;
            block_out <= state_upd;
            out_valid <= 1'b1;
            sbox_en   <= 1'b0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              state_reg <= block_in;
              idx       <= '0;
              sbox_en   <= 1'b1;
              state     <= RUN;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          sbox_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule
